// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

  // Controller states; encodings are visible on the ctrl_state port.
  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_MEM_WAIT = 2'd1,
    CTRL_HALT     = 2'd2
  } ctrl_state_t;

  // Register x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  localparam logic [4:0] ZERO_REG_IDX = 5'd0;

  // Bundle of every pipeline control line produced by the priority decode.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
  } ctrl_out_t;

  // A source operand depends on the load only if it is really read and the indices match.
  function automatic logic src_depends(input logic       uses,
                                       input logic [4:0] rs,
                                       input logic [4:0] rd);
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter
  import pipeline_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_ONE = W'(1);
  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: step by one when asked, but stick at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Counter register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard and sequencing controller for the 5-stage in-order pipeline.
// Produces PC / pipeline-register enables, flushes and the MEM/WB bubble from
// load-use detection, EX branch redirects and the data-memory handshake, and
// halts the pipeline permanently if memory stops acknowledging.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_vld,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_ex_vld,
  input  logic             id_ex_is_load,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_take_br,
  input  logic             ex_mem_req,
  input  logic             dm_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic [1:0]       ctrl_state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_t       state_q;
  ctrl_state_t       state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;

  logic      mem_stall;
  logic      lu_haz;
  logic      halted;
  logic      stall_inc;
  logic      flush_inc;
  ctrl_out_t ctrl;

  // Memory stall and load-use hazard terms; a load into x0 never blocks anyone.
  always_comb begin
    mem_stall = ex_mem_req & ~dm_ack;
    lu_haz    = id_vld & id_ex_vld & id_ex_is_load &
                (id_ex_rd != ZERO_REG_IDX) &
                (src_depends(id_uses_rs1, id_rs1, id_ex_rd) |
                 src_depends(id_uses_rs2, id_rs2, id_ex_rd));
    halted    = (state_q == CTRL_HALT);
  end

  // Next state and watchdog count: every stalled cycle counts, any unstalled
  // cycle clears it, and the stall that reaches the limit ends in HALT.
  // An ack on the limit cycle removes the stall, so the return to RUN wins.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (!halted) begin
      if (mem_stall) begin
        wait_d = wait_q + WAIT_ONE;
        if (wait_q == WAIT_LIMIT) begin
          state_d = CTRL_HALT;
        end else begin
          state_d = CTRL_MEM_WAIT;
        end
      end else begin
        wait_d  = '0;
        state_d = CTRL_RUN;
      end
    end
  end

  // State and watchdog registers; only reset leaves HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CTRL_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Priority decode of the pipeline controls. A memory stall outranks a taken
  // branch so a branch held in EX is only acted on once the pipeline moves,
  // and a branch outranks a load-use hazard because the dependent instruction
  // is squashed anyway.
  always_comb begin
    ctrl      = '0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (halted) begin
      ctrl = '0;
    end else if (mem_stall) begin
      ctrl.mem_wb_en     = 1'b1;
      ctrl.mem_wb_bubble = 1'b1;
      stall_inc          = 1'b1;
    end else if (ex_take_br) begin
      ctrl.pc_en       = 1'b1;
      ctrl.if_id_en    = 1'b1;
      ctrl.id_ex_en    = 1'b1;
      ctrl.ex_mem_en   = 1'b1;
      ctrl.mem_wb_en   = 1'b1;
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
      flush_inc        = 1'b1;
    end else if (lu_haz) begin
      ctrl.id_ex_en    = 1'b1;
      ctrl.id_ex_flush = 1'b1;
      ctrl.ex_mem_en   = 1'b1;
      ctrl.mem_wb_en   = 1'b1;
      stall_inc        = 1'b1;
    end else begin
      ctrl.pc_en     = 1'b1;
      ctrl.if_id_en  = 1'b1;
      ctrl.id_ex_en  = 1'b1;
      ctrl.ex_mem_en = 1'b1;
      ctrl.mem_wb_en = 1'b1;
    end
  end

  assign pc_en         = ctrl.pc_en;
  assign if_id_en      = ctrl.if_id_en;
  assign id_ex_en      = ctrl.id_ex_en;
  assign ex_mem_en     = ctrl.ex_mem_en;
  assign mem_wb_en     = ctrl.mem_wb_en;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;
  assign ctrl_state    = state_q;
  assign mem_timeout   = halted;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl with a queue-based scoreboard.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int MT = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_vld, id_uses_rs1, id_uses_rs2, id_ex_vld, id_ex_is_load;
  logic [4:0]    id_rs1, id_rs2, id_ex_rd;
  logic          ex_take_br, ex_mem_req, dm_ack;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, mem_wb_bubble;
  logic [1:0]    ctrl_state;
  logic          mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_vld        (id_vld),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .id_ex_vld     (id_ex_vld),
    .id_ex_is_load (id_ex_is_load),
    .id_ex_rd      (id_ex_rd),
    .ex_take_br    (ex_take_br),
    .ex_mem_req    (ex_mem_req),
    .dm_ack        (dm_ack),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_ex_en      (id_ex_en),
    .ex_mem_en     (ex_mem_en),
    .mem_wb_en     (mem_wb_en),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .mem_wb_bubble (mem_wb_bubble),
    .ctrl_state    (ctrl_state),
    .mem_timeout   (mem_timeout),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Expected decode class of a cycle, named after the controller's priority cases.
  typedef enum int {K_NORM, K_LU, K_BR, K_MEM, K_HALT} kind_t;

  typedef struct {
    string         tag;
    logic [4:0]    en;
    logic [2:0]    fl;
    logic [1:0]    st;
    logic          to;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t          sb[$];
  int            checks   = 0;
  int            failures = 0;
  logic [CW-1:0] mStall   = '0;
  logic [CW-1:0] mFlush   = '0;

  function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) return v;
    return CW'(v + 1'b1);
  endfunction

  // Drive one cycle of inputs and push the outputs the controller must show for it.
  task automatic applyStimulus(input string tag,
                               input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic exv, input logic ld,
                               input logic [4:0] rd, input logic br, input logic req,
                               input logic ack, input kind_t k, input logic [1:0] st);
    exp_t e;
    id_vld = vld; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_ex_vld = exv; id_ex_is_load = ld; id_ex_rd = rd;
    ex_take_br = br; ex_mem_req = req; dm_ack = ack;
    e.tag = tag;
    case (k)
      K_HALT:  begin e.en = 5'b00000; e.fl = 3'b000; end
      K_MEM:   begin e.en = 5'b00001; e.fl = 3'b001; end
      K_BR:    begin e.en = 5'b11111; e.fl = 3'b110; end
      K_LU:    begin e.en = 5'b00111; e.fl = 3'b010; end
      default: begin e.en = 5'b11111; e.fl = 3'b000; end
    endcase
    e.st = st;
    e.to = (k == K_HALT);
    e.sc = mStall;
    e.fc = mFlush;
    sb.push_back(e);
    if (k == K_MEM || k == K_LU) mStall = satInc(mStall);
    if (k == K_BR) mFlush = satInc(mFlush);
  endtask

  // Pop the oldest expectation and compare it field by field with the DUT.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty observed=0 entries expected=1");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} === e.en) else begin
      failures++;
      $error("[TB] FAIL %s_en observed=%b expected=%b", e.tag,
             {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, e.en);
    end
    checks++;
    assert ({if_id_flush, id_ex_flush, mem_wb_bubble} === e.fl) else begin
      failures++;
      $error("[TB] FAIL %s_flush observed=%b expected=%b", e.tag,
             {if_id_flush, id_ex_flush, mem_wb_bubble}, e.fl);
    end
    checks++;
    assert (ctrl_state === e.st) else begin
      failures++;
      $error("[TB] FAIL %s_state observed=%0d expected=%0d", e.tag, ctrl_state, e.st);
    end
    checks++;
    assert (mem_timeout === e.to) else begin
      failures++;
      $error("[TB] FAIL %s_timeout observed=%b expected=%b", e.tag, mem_timeout, e.to);
    end
    checks++;
    assert (stall_cnt === e.sc) else begin
      failures++;
      $error("[TB] FAIL %s_stall_cnt observed=%0d expected=%0d", e.tag, stall_cnt, e.sc);
    end
    checks++;
    assert (flush_cnt === e.fc) else begin
      failures++;
      $error("[TB] FAIL %s_flush_cnt observed=%0d expected=%0d", e.tag, flush_cnt, e.fc);
    end
  endtask

  // One full cycle: drive just after the rising edge, compare on the falling edge.
  task automatic step(input string tag,
                      input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic exv, input logic ld,
                      input logic [4:0] rd, input logic br, input logic req,
                      input logic ack, input kind_t k, input logic [1:0] st);
    applyStimulus(tag, vld, rs1, rs2, u1, u2, exv, ld, rd, br, req, ack, k, st);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic [1:0] st);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, K_NORM, st);
  endtask

  // Assert reset asynchronously, check the cleared state at once, then release it.
  task automatic doReset(input string tag);
    rst_n  = 1'b0;
    mStall = '0;
    mFlush = '0;
    #1;
    applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, K_NORM, CTRL_RUN);
    #1;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Hard bound on total run time.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence.
  initial begin
    rst_n = 1'b0;
    id_vld = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_ex_vld = 0; id_ex_is_load = 0; id_ex_rd = 0;
    ex_take_br = 0; ex_mem_req = 0; dm_ack = 0;
    #3;
    doReset("reset");

    // Load-use hazards and non-hazard look-alikes
    step("lu_rs2",      1, 0, 5, 0, 1, 1, 1, 5, 0, 0, 0, K_LU,   CTRL_RUN);
    step("lu_after",    1, 0, 5, 0, 1, 1, 0, 5, 0, 0, 0, K_NORM, CTRL_RUN);
    step("load_x0",     1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, K_NORM, CTRL_RUN);
    step("rs2_unused",  1, 0, 5, 0, 0, 1, 1, 5, 0, 0, 0, K_NORM, CTRL_RUN);
    step("lu_rs1",      1, 7, 3, 1, 0, 1, 1, 7, 0, 0, 0, K_LU,   CTRL_RUN);
    step("not_load",    1, 7, 3, 1, 0, 1, 0, 7, 0, 0, 0, K_NORM, CTRL_RUN);
    step("id_invalid",  0, 7, 3, 1, 0, 1, 1, 7, 0, 0, 0, K_NORM, CTRL_RUN);
    step("br_plus_haz", 1, 0, 5, 0, 1, 1, 1, 5, 1, 0, 0, K_BR,   CTRL_RUN);
    idle("after_br", CTRL_RUN);

    // Memory wait of three cycles, with a branch held in EX during the stall
    doReset("reset_mw");
    step("mw1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_MEM,  CTRL_RUN);
    step("mw2_br",  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, K_MEM,  CTRL_MEM_WAIT);
    step("mw3_haz", 1, 0, 5, 0, 1, 1, 1, 5, 0, 1, 0, K_MEM,  CTRL_MEM_WAIT);
    step("mw_ack",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, K_NORM, CTRL_MEM_WAIT);
    idle("mw_done", CTRL_RUN);

    // Watchdog timeout into HALT, then reset out of HALT
    doReset("reset_to");
    step("to1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_MEM,  CTRL_RUN);
    step("to2",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_MEM,  CTRL_MEM_WAIT);
    step("to3",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_MEM,  CTRL_MEM_WAIT);
    step("to4",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_MEM,  CTRL_MEM_WAIT);
    step("halt1",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_HALT, CTRL_HALT);
    step("halt_ack",1, 0, 5, 0, 1, 1, 1, 5, 1, 1, 1, K_HALT, CTRL_HALT);
    step("halt_idle",0,0, 0, 0, 0, 0, 0, 0, 0, 0, 0, K_HALT, CTRL_HALT);
    doReset("halt_reset");
    idle("post_halt", CTRL_RUN);

    // Ack arriving on the limit cycle beats the timeout
    step("al1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_MEM,  CTRL_RUN);
    step("al2",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_MEM,  CTRL_MEM_WAIT);
    step("al3",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_MEM,  CTRL_MEM_WAIT);
    step("al_ack",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, K_NORM, CTRL_MEM_WAIT);
    idle("al_run", CTRL_RUN);

    // Five back-to-back load-use stalls saturate the 2-bit stall counter
    doReset("reset_sat");
    for (int i = 0; i < 5; i++) begin
      step("sat_lu", 1, 0, 9, 0, 1, 1, 1, 9, 0, 0, 0, K_LU, CTRL_RUN);
    end
    idle("sat_hold", CTRL_RUN);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the 5-stage in-order pipeline. It drives the PC enable and the IF/ID, ID/EX, EX/MEM and MEM/WB register enables. It also drives the bubble and flush controls for those registers. Decisions come from three sources: load-use detection, taken-branch redirects from EX, and a variable-latency data-memory handshake. A timeout watchdog halts the pipeline if memory never acknowledges. Saturating counters record stall cycles and flush events.

## Interface
- MEM_TIMEOUT, 64, number of consecutive memory-stall cycles before the block enters HALT; legal values are 2 or more.
- CNT_W, 32, width of each performance counter.
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- id_vld  input  1  the instruction in ID is valid.
- id_rs1, id_rs2  input  5  source register indices of the instruction in ID.
- id_uses_rs1, id_uses_rs2  input  1  the instruction in ID actually reads the corresponding source register.
- id_ex_vld  input  1  the ID/EX register holds a valid instruction.
- id_ex_is_load  input  1  the ID/EX instruction is a load.
- id_ex_rd  input  5  destination register of the ID/EX instruction.
- ex_take_br  input  1  EX resolves a taken branch or jump this cycle.
- ex_mem_req  input  1  the EX/MEM register holds a valid load or store.
- dm_ack  input  1  data memory completes the pending access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1  update enables for the PC and each pipeline register.
- if_id_flush, id_ex_flush, mem_wb_bubble  output  1  load NOOP / invalid into that register on an enabled edge.
- ctrl_state  output  2  current controller state.
- mem_timeout  output  1  sticky error flag, asserted while the block is in HALT.
- stall_cnt, flush_cnt  output  CNT_W  saturating performance counters.

## Operation
Derived terms:
- **mem_stall** = ex_mem_req & ~dm_ack.
- **lu_haz** = id_vld & id_ex_vld & id_ex_is_load & (id_ex_rd != 0) & ((id_uses_rs1 & id_rs1 == id_ex_rd) | (id_uses_rs2 & id_rs2 == id_ex_rd)).

Controller states:
- **RUN**: normal operation.
- **MEM_WAIT**: the pipeline is frozen waiting for dm_ack.
- **HALT**: the pipeline is frozen permanently. Only rst_n exits HALT.

State transitions:
- RUN goes to MEM_WAIT when mem_stall is 1.
- MEM_WAIT goes to RUN on dm_ack.
- MEM_WAIT goes to HALT when mem_stall is 1 and wait_cnt == MEM_TIMEOUT-1.
- RUN goes directly to HALT if MEM_TIMEOUT is reached while still in RUN (the same rule applies in RUN).

Output decode, highest priority first:
1. **HALT**: all enables are 0; all flush and bubble outputs are 0.
2. **mem_stall** (in RUN or MEM_WAIT):
   - pc_en, if_id_en, id_ex_en and ex_mem_en are 0.
   - mem_wb_en = 1 and mem_wb_bubble = 1, so WB does not repeat the previous write.
3. **ex_take_br**:
   - All enables are 1.
   - if_id_flush = 1 and id_ex_flush = 1; the PC loads the branch target.
   - Any lu_haz in the same cycle is ignored, because its instruction is squashed.
4. **lu_haz**:
   - pc_en = 0 and if_id_en = 0.
   - id_ex_en = 1 with id_ex_flush = 1; ex_mem_en = 1 and mem_wb_en = 1.
5. **Otherwise**: all enables are 1; all flush and bubble outputs are 0.

Registered state:
- **wait_cnt** (width $clog2(MEM_TIMEOUT+1)):
  - Increments on each cycle where mem_stall is 1.
  - Clears on any cycle where mem_stall is 0.
- **stall_cnt**: +1 on each cycle in case 2 or case 4. Saturates at all-ones.
- **flush_cnt**: +1 on each cycle in case 3. Saturates at all-ones.
- A taken branch that is held in EX during a memory stall is not flushed or counted until the cycle in which the pipeline advances.

## Timing
- Enables, flushes and the bubble are combinational from the inputs and the current state, with zero-cycle latency. ctrl_state, wait_cnt and the counters are registered.
- Reset (rst_n = 0, asynchronous) sets:
  - ctrl_state = RUN, wait_cnt = 0, mem_timeout = 0, stall_cnt = 0, flush_cnt = 0.
  - The enables decode as in RUN.
- dm_ack arriving on the same cycle that wait_cnt reaches MEM_TIMEOUT-1 wins: the controller returns to RUN with no HALT.
- A load-use hazard costs exactly one bubble; on the following cycle lu_haz is 0 because the load has moved to EX/MEM.
- A memory stall lasting N cycles (N < MEM_TIMEOUT) adds N stall_cnt increments and N MEM/WB bubbles.
- HALT is entered on the edge ending stalled cycle number MEM_TIMEOUT.
- rst_n asserted mid-wait or in HALT clears everything immediately.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - enum ctrl_state_t: CTRL_RUN = 2'd0, CTRL_MEM_WAIT = 2'd1, CTRL_HALT = 2'd2.
  - ZERO_REG_IDX.
- Sub-module sat_counter (parameter W; inputs clk, rst_n, inc; output cnt) is instantiated twice, for stall_cnt and flush_cnt.
- The FSM, wait_cnt and the priority decode live in pipeline_ctrl.

## Test plan
- **Load-use**: id_ex_is_load = 1, id_ex_rd = 5, id_rs2 = 5, id_uses_rs2 = 1 -> one cycle with pc_en = 0, if_id_en = 0, id_ex_flush = 1; stall_cnt goes 0 to 1.
- **Load to x0**: same as the load-use case but with id_ex_rd = 0, or with id_uses_rs2 = 0 -> no stall; all enables are 1.
- **Branch plus hazard**: ex_take_br = 1 together with lu_haz -> if_id_flush = 1, id_ex_flush = 1, pc_en = 1; flush_cnt = 1; stall_cnt unchanged.
- **Memory wait**: ex_mem_req = 1, dm_ack low for 3 cycles then high -> ctrl_state = MEM_WAIT for 3 cycles, mem_wb_bubble = 1 on each, stall_cnt = 3, then RUN.
- **Timeout**: MEM_TIMEOUT = 4 with dm_ack never asserted -> HALT after 4 cycles, mem_timeout = 1, all enables 0; a rst_n pulse returns the block to RUN with the counters at 0.
- **Ack at limit, then counter saturation**:
  - dm_ack asserted on stalled cycle 4 with MEM_TIMEOUT = 4 -> no HALT.
  - Then, with CNT_W = 2 and 5 load-use stalls, stall_cnt holds at 3.
